// File: rtl/edge_pkg.sv
// Shared constants and state encoding for the edge-detection datapath.
// Imported by the feeder and anything else that walks image strips.
package edge_pkg;

   localparam int unsigned STRIP_W    = 16;
   localparam int unsigned STRIP_STEP = 14;
   localparam int unsigned PIX_BITS   = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      ISSUE,
      WAIT
   } feeder_state_e;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter: counts 0..rollover_val then wraps to 0.
// rollover_flag is high while the count equals rollover_val.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/gradient_feeder.sv
// Walks a 16-pixel-wide strip down the frame, fetching one row slice per anchor
// step from byte-wide image memory and handing it to the gradient controller.
module gradient_feeder
   import edge_pkg::*;
#(
   parameter int unsigned IMG_W     = 640,
   parameter int unsigned IMG_H     = 480,
   parameter int unsigned ADDR_BITS = 20
) (
   input  logic                                clk,
   input  logic                                n_rst,
   input  logic                                start,
   output logic                                mem_rd,
   output logic [ADDR_BITS-1:0]                mem_addr,
   input  logic [PIX_BITS-1:0]                 mem_rdata,
   output logic [STRIP_W-1:0][PIX_BITS-1:0]    gradient_in,
   output logic                                anchor_moving,
   output logic [31:0]                         anchor_x,
   output logic [31:0]                         anchor_y,
   input  logic                                gradient_final,
   output logic                                busy,
   output logic                                frame_done
);

   localparam longint FRAME_PIX = 64'(IMG_W) * 64'(IMG_H);

   if (FRAME_PIX > (64'd1 << ADDR_BITS)) begin : g_addr_check
      $error("gradient_feeder: IMG_W*IMG_H does not fit in ADDR_BITS");
   end

   feeder_state_e                      state_q, state_d;
   logic [31:0]                        strip_col_q, strip_col_d;
   logic [31:0]                        row_q, row_d;
   logic [ADDR_BITS-1:0]               row_base_q, row_base_d;
   logic [ADDR_BITS-1:0]               addr_hold_q, addr_hold_d;
   logic [31:0]                        anchor_x_q, anchor_x_d;
   logic [31:0]                        anchor_y_q, anchor_y_d;
   logic [STRIP_W-1:0][PIX_BITS-1:0]   slice_q, slice_d;
   logic                               cap_q, cap_d;
   logic                               cap_rd_q, cap_rd_d;
   logic [3:0]                         cap_idx_q, cap_idx_d;
   logic                               frame_done_q, frame_done_d;

   logic [3:0]                         byte_idx;
   logic                               byte_last;
   logic [31:0]                        col;
   logic                               col_in;
   logic [ADDR_BITS-1:0]               rd_addr;

   flex_counter #(
      .NUM_CNT_BITS (4)
   ) u_byte_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (state_q != FETCH),
      .count_enable  (state_q == FETCH),
      .rollover_val  (4'(STRIP_W - 1)),
      .count_out     (byte_idx),
      .rollover_flag (byte_last)
   );

   assign col     = strip_col_q + 32'(byte_idx);
   assign col_in  = (col < IMG_W);
   assign rd_addr = row_base_q + ADDR_BITS'(col);

   // Columns past the right edge are not read; their slots are zero-filled.
   assign mem_rd   = (state_q == FETCH) && col_in;
   assign mem_addr = mem_rd ? rd_addr : addr_hold_q;

   always_comb begin
      state_d      = state_q;
      strip_col_d  = strip_col_q;
      row_d        = row_q;
      row_base_d   = row_base_q;
      addr_hold_d  = mem_addr;
      anchor_x_d   = anchor_x_q;
      anchor_y_d   = anchor_y_q;
      slice_d      = slice_q;
      cap_d        = 1'b0;
      cap_rd_d     = 1'b0;
      cap_idx_d    = byte_idx;
      frame_done_d = 1'b0;

      // Read data lands one cycle after the strobe, so capture lags the fetch index.
      if (cap_q) begin
         slice_d[cap_idx_q] = cap_rd_q ? mem_rdata : '0;
      end

      unique case (state_q)
         IDLE: begin
            if (start && !frame_done_q) begin
               state_d     = FETCH;
               strip_col_d = '0;
               row_d       = '0;
               row_base_d  = '0;
            end
         end
         FETCH: begin
            cap_d    = 1'b1;
            cap_rd_d = mem_rd;
            if (byte_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d    = ISSUE;
            anchor_x_d = row_q + 32'd1;
            anchor_y_d = strip_col_q;
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (gradient_final) begin
               if (row_q < IMG_H - 1) begin
                  state_d    = FETCH;
                  row_d      = row_q + 32'd1;
                  row_base_d = row_base_q + ADDR_BITS'(IMG_W);
               end else if (strip_col_q + STRIP_STEP < IMG_W - 2) begin
                  state_d     = FETCH;
                  strip_col_d = strip_col_q + STRIP_STEP;
                  row_d       = '0;
                  row_base_d  = '0;
               end else begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         strip_col_q  <= '0;
         row_q        <= '0;
         row_base_q   <= '0;
         addr_hold_q  <= '0;
         anchor_x_q   <= '0;
         anchor_y_q   <= '0;
         slice_q      <= '0;
         cap_q        <= 1'b0;
         cap_rd_q     <= 1'b0;
         cap_idx_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         strip_col_q  <= strip_col_d;
         row_q        <= row_d;
         row_base_q   <= row_base_d;
         addr_hold_q  <= addr_hold_d;
         anchor_x_q   <= anchor_x_d;
         anchor_y_q   <= anchor_y_d;
         slice_q      <= slice_d;
         cap_q        <= cap_d;
         cap_rd_q     <= cap_rd_d;
         cap_idx_q    <= cap_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign gradient_in   = slice_q;
   assign anchor_moving = (state_q == ISSUE);
   assign anchor_x      = anchor_x_q;
   assign anchor_y      = anchor_y_q;
   assign busy          = (state_q != IDLE);
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_gradient_feeder.sv
// Bench for gradient_feeder: a 30x3 instance for the frame-walk scenarios and a
// 20x1 instance for right-edge padding, both backed by mem[a] = a[7:0].
module tb_gradient_feeder;

   localparam int unsigned AW = 30;
   localparam int unsigned AH = 3;
   localparam int unsigned BW = 20;
   localparam int unsigned BH = 1;
   localparam int unsigned ABITS = 20;

   typedef struct {
      int                     x;
      int                     y;
      logic [15:0][7:0]       slice;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   logic               start_a = 1'b0, gf_a = 1'b0;
   logic               mem_rd_a, am_a, busy_a, fd_a;
   logic [ABITS-1:0]   mem_addr_a;
   logic [7:0]         rdata_a = '0;
   logic [15:0][7:0]   gin_a;
   logic [31:0]        ax_a, ay_a;

   logic               start_b = 1'b0, gf_b = 1'b0;
   logic               mem_rd_b, am_b, busy_b, fd_b;
   logic [ABITS-1:0]   mem_addr_b;
   logic [7:0]         rdata_b = '0;
   logic [15:0][7:0]   gin_b;
   logic [31:0]        ax_b, ay_b;

   int   n_checks = 0;
   int   n_fail = 0;
   int   rd_cnt_b = 0;
   exp_t exp_q[$];

   gradient_feeder #(.IMG_W(AW), .IMG_H(AH), .ADDR_BITS(ABITS)) dut_a (
      .clk(clk), .n_rst(n_rst), .start(start_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a),
      .mem_rdata(rdata_a), .gradient_in(gin_a), .anchor_moving(am_a), .anchor_x(ax_a),
      .anchor_y(ay_a), .gradient_final(gf_a), .busy(busy_a), .frame_done(fd_a)
   );

   gradient_feeder #(.IMG_W(BW), .IMG_H(BH), .ADDR_BITS(ABITS)) dut_b (
      .clk(clk), .n_rst(n_rst), .start(start_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
      .mem_rdata(rdata_b), .gradient_in(gin_b), .anchor_moving(am_b), .anchor_x(ax_b),
      .anchor_y(ay_b), .gradient_final(gf_b), .busy(busy_b), .frame_done(fd_b)
   );

   always @(posedge clk) begin
      if (mem_rd_a) rdata_a <= mem_addr_a[7:0];
      if (mem_rd_b) rdata_b <= mem_addr_b[7:0];
      if (mem_rd_b) rd_cnt_b <= rd_cnt_b + 1;
   end

   function automatic void push_frame(input int w, input int h);
      exp_t e;
      for (int s = 0; s < w - 2; s += 14) begin
         for (int r = 0; r < h; r++) begin
            e.x = r + 1;
            e.y = s;
            for (int i = 0; i < 16; i++) begin
               e.slice[i] = (s + i < w) ? 8'((r * w + s + i) % 256) : 8'h00;
            end
            exp_q.push_back(e);
         end
      end
   endfunction

   // Waits for anchor_moving on dut_a; cnt is the cycle index since the trigger edge.
   task automatic wait_anchor_a(input bit spurious, output int cnt);
      cnt = 1;
      while (!am_a && cnt < 60) begin
         if (spurious) begin
            gf_a    = (cnt == 3);
            start_a = (cnt == 5);
         end
         @(negedge clk);
         cnt++;
      end
      gf_a    = 1'b0;
      start_a = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({mem_rd_a, mem_addr_a, gin_a, am_a, ax_a, ay_a, busy_a, fd_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: got rd=%b addr=%h x=%0d y=%0d busy=%b done=%b, want all 0",
                  mem_rd_a, mem_addr_a, ax_a, ay_a, busy_a, fd_a);
      end
      n_checks++;
      if ({mem_rd_b, mem_addr_b, gin_b, am_b, ax_b, ay_b, busy_b, fd_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: got busy=%b x=%0d y=%0d, want all 0", busy_b, ax_b, ay_b);
      end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0 || am_a !== 1'b0 || mem_rd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b am=%b rd=%b, want 0 0 0",
                  busy_a, am_a, mem_rd_a);
      end
   endtask

   task automatic test_reset_mid_wait();
      int cnt;
      exp_t e;
      exp_q.delete();
      push_frame(AW, AH);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_anchor_a(1'b0, cnt);
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_rd_a, mem_addr_a, gin_a, am_a, ax_a, ay_a, busy_a, fd_a} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b x=%0d y=%0d gin=%h, want all 0",
                  busy_a, ax_a, ay_a, gin_a);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_anchor_a(1'b0, cnt);
      e = exp_q.pop_front();
      n_checks++;
      if (cnt != 18 || ax_a !== 32'(e.x) || ay_a !== 32'(e.y)) begin
         n_fail++;
         $display("FAIL restart: got cycle=%0d x=%0d y=%0d, want 18 %0d %0d",
                  cnt, ax_a, ay_a, e.x, e.y);
      end
      n_checks++;
      if (gin_a !== e.slice) begin
         n_fail++;
         $display("FAIL restart_slice: got %h want %h", gin_a, e.slice);
      end
      #2 n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_frame(input string tag, input bit spurious, input bit hold);
      int               cnt;
      int               rd_seen;
      bit               moved;
      exp_t             e;
      logic [15:0][7:0] snap;
      logic [31:0]      snap_x, snap_y;
      exp_q.delete();
      push_frame(AW, AH);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_anchor_a(spurious, cnt);
         n_checks++;
         if (!am_a) begin
            n_fail++;
            $display("FAIL %s timeout: no anchor_moving for pulse %0d", tag, k);
            return;
         end
         n_checks++;
         if (cnt != 18) begin
            n_fail++;
            $display("FAIL %s latency: pulse %0d at cycle %0d, want 18", tag, k, cnt);
         end
         e = exp_q.pop_front();
         n_checks++;
         if (ax_a !== 32'(e.x) || ay_a !== 32'(e.y)) begin
            n_fail++;
            $display("FAIL %s anchor: pulse %0d got (%0d,%0d) want (%0d,%0d)",
                     tag, k, ax_a, ay_a, e.x, e.y);
         end
         n_checks++;
         if (gin_a !== e.slice) begin
            n_fail++;
            $display("FAIL %s slice: pulse %0d got %h want %h", tag, k, gin_a, e.slice);
         end
         if (spurious) gf_a = 1'b1;
         moved = 1'b0;
         for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            gf_a = 1'b0;
            if (am_a) moved = 1'b1;
         end
         n_checks++;
         if (moved) begin
            n_fail++;
            $display("FAIL %s early_advance: got extra anchor_moving after pulse %0d, want none",
                     tag, k);
         end
         if (hold && k == 0) begin
            snap    = gin_a;
            snap_x  = ax_a;
            snap_y  = ay_a;
            rd_seen = 0;
            for (int d = 0; d < 100; d++) begin
               @(negedge clk);
               if (mem_rd_a) rd_seen++;
               if (gin_a !== snap || ax_a !== snap_x || ay_a !== snap_y || am_a) moved = 1'b1;
            end
            n_checks++;
            if (rd_seen != 0) begin
               n_fail++;
               $display("FAIL %s hold_rd: got %0d reads while waiting, want 0", tag, rd_seen);
            end
            n_checks++;
            if (moved) begin
               n_fail++;
               $display("FAIL %s hold_stable: got outputs changing while waiting, want stable",
                        tag);
            end
         end
         gf_a = 1'b1;
         @(negedge clk);
         gf_a = 1'b0;
      end
      n_checks++;
      if (fd_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL %s frame_done: got done=%b busy=%b, want 1 0", tag, fd_a, busy_a);
      end
      if (spurious) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n_checks++;
      if (fd_a !== 1'b0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: got done=%b busy=%b, want 0 0", tag, fd_a, busy_a);
      end
      moved = 1'b0;
      for (int d = 0; d < 30; d++) begin
         if (busy_a || am_a || mem_rd_a) moved = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (moved) begin
         n_fail++;
         $display("FAIL %s stays_idle: got activity after frame_done, want none", tag);
      end
   endtask

   task automatic test_edge_padding();
      int               cnt;
      int               base;
      logic [15:0]      pattern;
      logic [ABITS-1:0] first_addr, hold_addr;
      exp_t             e;
      exp_q.delete();
      push_frame(BW, BH);
      base = rd_cnt_b;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            for (int c = 0; c < 16; c++) begin
               pattern[c] = mem_rd_b;
               if (c == 0) first_addr = mem_addr_b;
               @(negedge clk);
            end
            hold_addr = mem_addr_b;
            cnt = 17;
            n_checks++;
            if (pattern !== 16'h003f) begin
               n_fail++;
               $display("FAIL pad_rd_pattern: got %b want %b", pattern, 16'h003f);
            end
            n_checks++;
            if (first_addr !== ABITS'(14) || hold_addr !== ABITS'(19)) begin
               n_fail++;
               $display("FAIL pad_addr: got first=%0d held=%0d, want 14 19",
                        first_addr, hold_addr);
            end
         end else begin
            cnt = 1;
         end
         while (!am_b && cnt < 60) begin
            @(negedge clk);
            cnt++;
         end
         e = exp_q.pop_front();
         n_checks++;
         if (!am_b || cnt != 18 || ax_b !== 32'(e.x) || ay_b !== 32'(e.y)) begin
            n_fail++;
            $display("FAIL pad_anchor %0d: got am=%b cycle=%0d (%0d,%0d), want 1 18 (%0d,%0d)",
                     k, am_b, cnt, ax_b, ay_b, e.x, e.y);
         end
         n_checks++;
         if (gin_b !== e.slice) begin
            n_fail++;
            $display("FAIL pad_slice %0d: got %h want %h", k, gin_b, e.slice);
         end
         repeat (3) @(negedge clk);
         gf_b = 1'b1;
         @(negedge clk);
         gf_b = 1'b0;
      end
      n_checks++;
      if (fd_b !== 1'b1 || rd_cnt_b - base != 22) begin
         n_fail++;
         $display("FAIL pad_done: got done=%b reads=%0d, want 1 22", fd_b, rd_cnt_b - base);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_reset_mid_wait();
      run_frame("single_frame", 1'b0, 1'b0);
      run_frame("timing_hold", 1'b0, 1'b1);
      run_frame("spurious", 1'b1, 1'b0);
      test_edge_padding();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/gradient_feeder.md
Name: gradient_feeder

Overview:
- Initiator side of the gradient controller's anchor/row interface.
- Walks a 3x3-window anchor over a frame stored in byte-wide image memory, one 16-pixel-wide vertical strip at a time.
- For each anchor step it fetches one 16-pixel row slice, presents it on gradient_in, pulses anchor_moving, then waits for gradient_final before advancing.
- Sits between the image SRAM and gradient_controller.

Parameters:
- IMG_W, 640, frame width in pixels (>= 16)
- IMG_H, 480, frame height in pixels (>= 1)
- ADDR_BITS, 20, image memory address width

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin a frame
- mem_rd  out  1  image memory read strobe
- mem_addr  out  ADDR_BITS  byte address, row-major (y*IMG_W + x)
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- gradient_in  out  16x8  current row slice, element i = pixel at column strip_col+i
- anchor_moving  out  1  single-cycle pulse; new row slice valid on gradient_in
- anchor_x  out  32  1-based row index within current strip (1..IMG_H); value 1 marks first row of a strip
- anchor_y  out  32  strip start column (0, 14, 28, ...)
- gradient_final  in  1  consumer finished processing the last issued slice
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  single-cycle pulse after last slice of last strip is acknowledged

Behaviour:
- Reset (async, any time, including mid-fetch or mid-wait): state IDLE; mem_rd=0, mem_addr=0, gradient_in=0, anchor_moving=0, anchor_x=0, anchor_y=0, busy=0, frame_done=0; all counters cleared.
- Strip geometry:
  - strips start at columns 0, 14, 28, ... while strip_col < IMG_W-2; NUM_STRIPS = ceil((IMG_W-2)/14).
  - adjacent strips overlap by 2 columns.
- States:
  - IDLE: start -> FETCH with strip_col=0, row=0, row_base=0, byte index=0, busy=1.
  - FETCH (16 cycles, byte index i=0..15): col = strip_col+i.
    - If col < IMG_W: mem_rd=1, mem_addr=row_base+col.
    - Else: mem_rd=0 and slot i is zero-filled.
    - Data returned 1 cycle later is written to gradient_in[i]. After i=15 -> DRAIN.
  - DRAIN (1 cycle): capture slot 15 -> ISSUE.
  - ISSUE (1 cycle): anchor_moving=1, anchor_x=row+1, anchor_y=strip_col -> WAIT.
  - WAIT: hold gradient_in, anchor_x and anchor_y stable until gradient_final=1, then:
    - if row < IMG_H-1: row++, row_base += IMG_W (adder only, no multiplier), -> FETCH.
    - else if next strip exists: strip_col += 14, row=0, row_base=0, -> FETCH.
    - else: frame_done=1 for 1 cycle, busy=0, -> IDLE.
- Latency: anchor_moving is high in the 18th cycle after the edge that samples start (16 FETCH + DRAIN + ISSUE). Each subsequent slice is issued 18 cycles after the edge that samples gradient_final.
- gradient_in must not change during the anchor_moving cycle. It updates slot by slot during the next FETCH only.
- Ignored inputs:
  - start while busy.
  - gradient_final outside WAIT, including in the ISSUE cycle itself.
- A start coincident with frame_done is ignored; a new frame needs a fresh start pulse after IDLE.
- mem_addr holds its last value when mem_rd=0.
- Widths: row_base and mem_addr are ADDR_BITS wide; IMG_W*IMG_H must fit in ADDR_BITS (elaboration-time assertion).

Decomposition:
- Shared package edge_pkg:
  - STRIP_W=16, STRIP_STEP=14, PIX_BITS=8.
  - Feeder state enum {IDLE, FETCH, DRAIN, ISSUE, WAIT}.
- Byte index: reuse flex_counter (NUM_CNT_BITS=4, rollover 15).
- The rest is inline.

Test Plan:
- Reset mid-WAIT (IMG_W=30, IMG_H=3): drop n_rst -> all outputs 0 immediately (async); state IDLE; next start restarts at anchor_y=0, anchor_x=1.
- Single frame (IMG_W=30, IMG_H=3, memory mem[a]=a[7:0]):
  - start, then gradient_final 5 cycles after each anchor_moving.
  - Expect 6 anchor_moving pulses with (anchor_x, anchor_y) = (1,0),(2,0),(3,0),(1,14),(2,14),(3,14).
  - First slice gradient_in[i]=i; slice (2,14) gradient_in[i]=44+i.
  - frame_done 1 cycle after the 6th gradient_final is sampled.
- Edge padding (IMG_W=20, IMG_H=1):
  - Second strip (anchor_y=14): gradient_in[0..5]=14..19, gradient_in[6..15]=0.
  - mem_rd is low for exactly those 10 slots.
- Timing: anchor_moving appears exactly 18 cycles after the start edge. Holding gradient_final low 100 cycles -> no further mem_rd, and gradient_in/anchor_x stay stable.
- Spurious inputs:
  - gradient_final pulsed during FETCH and ISSUE -> ignored, no advance.
  - start pulsed while busy -> ignored; pulse count and sequence unchanged from the single-frame case.
